tile_fifo_sched: RTL and testbench
==================================

# tile_fifo_sched

Round-robin write scheduler and occupancy tracker for one tile FIFO shared by several tile producers. It grants the FIFO write port to one requester at a time for a fixed burst of words, and drives the FIFO write/read strobes and write data. It keeps an exact occupancy count, so consumers get `empty`/`count` and producers never overrun the buffer. It sits between the tile producers, the tile FIFO and the downstream tile consumer.

## Interface
Parameters:
- `NUM_REQ`, 4: number of producers; must be at least 2.
- `WIDTH`, 16: data word width; must match the FIFO `WIDTH`.
- `DEPTH`, 4: FIFO capacity in words; must match the FIFO `MAX_INPUT_TILES`.
- `BURST`, 2: words per grant; must satisfy 1 ≤ `BURST` ≤ `DEPTH`.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `req`  in  `NUM_REQ`  per-producer request; held high until the requester's burst completes.
- `req_data`  in  `NUM_REQ*WIDTH`  producer words; requester i occupies bits [i*WIDTH +: WIDTH].
- `grant`  out  `NUM_REQ`  one-hot grant; each cycle with `grant[i]` high consumes one word from producer i.
- `fifo_write`  out  1  FIFO write strobe.
- `fifo_wdata`  out  `WIDTH`  FIFO write data.
- `fifo_read`  out  1  FIFO read strobe.
- `fifo_full`  in  1  FIFO full flag, used for the error check only.
- `pop`  in  1  consumer read request.
- `empty`  out  1  high when `count` == 0.
- `count`  out  $clog2(`DEPTH`+1)  FIFO occupancy in words.
- `overflow_err`  out  1  sticky error flag.
- `underflow_err`  out  1  sticky error flag.

## Operation
- The FSM has two states, IDLE and BURST. Registers: `state`, `grant`, `winner` index, `beat` counter, round-robin pointer `rr_ptr`, `count`, and the two error flags.
- IDLE:
  - A grant is allowed only when some `req` bit is high and (`DEPTH` − `count`) ≥ `BURST`. `count` is the registered value; a pop in the same cycle is not credited.
  - The winner is the first set `req` bit searching from `rr_ptr` upward, wrapping modulo `NUM_REQ`.
  - On a grant: next state BURST, `grant` = one-hot(winner), `beat` = 0.
- BURST:
  - `fifo_write` = 1 and `fifo_wdata` = `req_data` slice of `winner`. Both are combinational from the registered state.
  - `beat` increments each cycle.
  - When `beat` == `BURST`−1: next state IDLE, `grant` = 0, `rr_ptr` = (`winner`+1) mod `NUM_REQ`.
  - The burst is never stalled and `req` is not re-sampled during it.
- Reads:
  - `fifo_read` = `pop` && (`count` != 0), combinational.
  - A pop while `count` == 0 is dropped and sets `underflow_err`.
- Count update: `count` += `fifo_write` − `fifo_read`. A simultaneous write and read leaves `count` unchanged.
- Errors:
  - `overflow_err` sets if `fifo_write` && `fifo_full` occurs, or if `count` would exceed `DEPTH`.
  - Both flags clear only on reset.
- Outside BURST, `fifo_wdata` = 0.

## Timing
- Reset values (`reset` low at a rising edge): state IDLE; `grant`, `beat`, `rr_ptr`, `count`, `winner` and both error flags = 0. Consequently `fifo_write` = 0, `fifo_read` = 0 (since `count` = 0), `empty` = 1, and `fifo_wdata` = 0.
- The FIFO shares this reset, so the controller and FIFO clear together.
- Grant latency: `req` seen in IDLE at edge N → `grant` and `fifo_write` high from N+1 through N+`BURST`.
- At least one IDLE cycle separates consecutive bursts. Sustained throughput is `BURST`/(`BURST`+1) words per cycle.
- `count` and `empty` reflect writes and reads one cycle after the strobe cycle.
- Reset mid-burst: the burst is abandoned and `grant`/`fifo_write` are low from the following cycle. Partially written words are lost with the FIFO reset. The producer must restart its tile.
- When `BURST` == `DEPTH`, a grant requires `count` == 0.

## Test plan
(Parameters: `NUM_REQ`=4, `WIDTH`=16, `DEPTH`=4, `BURST`=2.)
- Reset, no stimulus → `grant`=0000, `fifo_write`=0, `fifo_read`=0, `count`=0, `empty`=1, both errors 0.
- `req`=0100, producer 2 presents 0xA5A5 then 0x5A5A → `grant`=0100 for 2 cycles starting 1 cycle after request; `fifo_wdata` = 0xA5A5, 0x5A5A; `count`=2; `rr_ptr`=3.
- `req`=1111 held, consumer pops one word whenever `count` ≥ 2 → grant order 0,1,2,3,0; never two grants without an IDLE cycle between them; `overflow_err` stays 0.
- Fill to `count`=4, then `req`=1000 → no grant while `count` > 2. Pop twice → `count`=2, then `grant`=1000 the next cycle.
- With `count`=2, `pop`=1 during a BURST write cycle → `fifo_read`=1 and `count` holds at 2 that cycle. Later, with `count`=0 and `pop`=1 → `fifo_read`=0 and `underflow_err`=1, remaining 1 until reset.
- `reset` low during the 2nd burst beat → next cycle `grant`=0000, `count`=0, `empty`=1, errors 0. After release, `req`=0001 is granted normally starting from `rr_ptr`=0.

Source files
------------

// File: rtl/tile_fifo_sched_if.sv
// Producer, FIFO and consumer signals of the tile FIFO write scheduler.
// The scheduler connects as slave; the surrounding environment connects as master.
interface tile_fifo_sched_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 16,
  parameter int DEPTH   = 4
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]       grant;
  logic                     fifo_write;
  logic [WIDTH-1:0]         fifo_wdata;
  logic                     fifo_read;
  logic                     fifo_full;
  logic                     pop;
  logic                     empty;
  logic [CNT_W-1:0]         count;
  logic                     overflow_err;
  logic                     underflow_err;

  modport master (
    output req, req_data, fifo_full, pop,
    input  grant, fifo_write, fifo_wdata, fifo_read, empty, count,
           overflow_err, underflow_err
  );

  modport slave (
    input  req, req_data, fifo_full, pop,
    output grant, fifo_write, fifo_wdata, fifo_read, empty, count,
           overflow_err, underflow_err
  );
endinterface

// File: rtl/tile_fifo_sched.sv
// Round-robin burst write scheduler and exact occupancy tracker for a shared tile FIFO.
// A burst is granted only when the whole burst is guaranteed to fit.
module tile_fifo_sched #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 16,
  parameter int DEPTH   = 4,
  parameter int BURST   = 2
) (
  input  logic             clk,
  input  logic             reset,
  tile_fifo_sched_if.slave bus
);
  localparam int IDX_W  = $clog2(NUM_REQ);
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int BEAT_W = (BURST > 1) ? $clog2(BURST) : 1;

  localparam logic [IDX_W:0]    NREQ_EXT   = (IDX_W + 1)'(NUM_REQ);
  localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(NUM_REQ - 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT  = BEAT_W'(BURST - 1);
  localparam logic [CNT_W-1:0]  FULL_CNT   = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]  GRANT_LIM  = CNT_W'(DEPTH - BURST);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } state_e;

  state_e             state_q,  state_d;
  logic [NUM_REQ-1:0] grant_q,  grant_d;
  logic [IDX_W-1:0]   winner_q, winner_d;
  logic [BEAT_W-1:0]  beat_q,   beat_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]   count_q,  count_d;
  logic               ovf_q,    ovf_d;
  logic               unf_q,    unf_d;

  logic               pick_found;
  logic [IDX_W-1:0]   pick_idx;
  logic [IDX_W:0]     cand;
  logic               room_ok;
  logic               fifo_write;
  logic               fifo_read;

  // First requester at or above rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no latch can be inferred.
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr_q} + (IDX_W + 1)'(k);
      if (cand >= NREQ_EXT) cand = cand - NREQ_EXT;
      if (!pick_found && bus.req[cand[IDX_W-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = cand[IDX_W-1:0];
      end
    end
  end

  // Registered count only: a pop in the same cycle does not open room early.
  assign room_ok = (count_q <= GRANT_LIM);

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    winner_d = winner_q;
    beat_d   = beat_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      S_IDLE: begin
        if (pick_found && room_ok) begin
          state_d  = S_BURST;
          grant_d  = NUM_REQ'(1) << pick_idx;
          winner_d = pick_idx;
          beat_d   = '0;
        end
      end
      S_BURST: begin
        if (beat_q == LAST_BEAT) begin
          state_d  = S_IDLE;
          grant_d  = '0;
          beat_d   = '0;
          rr_ptr_d = (winner_q == LAST_IDX) ? '0 : winner_q + 1'b1;
        end else begin
          beat_d = beat_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign fifo_write = (state_q == S_BURST);
  assign fifo_read  = bus.pop && (count_q != '0);

  always_comb begin
    count_d = count_q;
    ovf_d   = ovf_q | (fifo_write & bus.fifo_full);
    unf_d   = unf_q | (bus.pop & (count_q == '0));
    if (fifo_write && !fifo_read) begin
      if (count_q == FULL_CNT) ovf_d = 1'b1;
      else                     count_d = count_q + 1'b1;
    end else if (!fifo_write && fifo_read) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous; it is only a data term sampled at the clock edge.
    if (!reset) begin
      state_q  <= S_IDLE;
      grant_q  <= '0;
      winner_q <= '0;
      beat_q   <= '0;
      rr_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q  <= state_d;
      grant_q  <= grant_d;
      winner_q <= winner_d;
      beat_q   <= beat_d;
      rr_ptr_q <= rr_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  assign bus.grant         = grant_q;
  assign bus.fifo_write    = fifo_write;
  assign bus.fifo_wdata    = fifo_write ? bus.req_data[winner_q*WIDTH +: WIDTH] : '0;
  assign bus.fifo_read     = fifo_read;
  assign bus.count         = count_q;
  assign bus.empty         = (count_q == '0);
  assign bus.overflow_err  = ovf_q;
  assign bus.underflow_err = unf_q;
endmodule

// File: tb/tb_tile_fifo_sched.sv
// Self-checking bench for tile_fifo_sched: directed scenarios plus randomized traffic
// compared cycle by cycle against a behavioural scheduler/occupancy model.
module tb_tile_fifo_sched;
  localparam int N  = 4;
  localparam int W  = 16;
  localparam int D  = 4;
  localparam int B  = 2;
  localparam int CW = $clog2(D + 1);
  localparam int VW = N + W + CW + 5;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  tile_fifo_sched_if #(.NUM_REQ(N), .WIDTH(W), .DEPTH(D)) bus ();

  tile_fifo_sched #(.NUM_REQ(N), .WIDTH(W), .DEPTH(D), .BURST(B)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Behavioural model: who owns the write port, words written so far, occupancy.
  int m_busy, m_owner, m_beat, m_ptr, m_count, m_ovf, m_unf;

  logic [VW-1:0] obs;
  assign obs = {bus.grant, bus.fifo_write, bus.fifo_wdata, bus.fifo_read,
                bus.count, bus.empty, bus.overflow_err, bus.underflow_err};

  function automatic logic [VW-1:0] exp_vec();
    logic [N-1:0] g;
    logic [W-1:0] wd;
    logic         rd;
    g  = '0;
    wd = '0;
    if (m_busy != 0) begin
      g[m_owner] = 1'b1;
      wd = bus.req_data[m_owner*W +: W];
    end
    rd = bus.pop && (m_count != 0);
    return {g, (m_busy != 0), wd, rd, CW'(m_count), (m_count == 0), (m_ovf != 0), (m_unf != 0)};
  endfunction

  task automatic model_step();
    int wr, rd, old;
    if (!reset) begin
      m_busy = 0; m_owner = 0; m_beat = 0; m_ptr = 0; m_count = 0; m_ovf = 0; m_unf = 0;
      return;
    end
    old = m_count;
    wr  = m_busy;
    rd  = (bus.pop && old != 0) ? 1 : 0;
    if (bus.pop && old == 0) m_unf = 1;
    if (wr != 0 && bus.fifo_full) m_ovf = 1;
    if (old + wr - rd > D) m_ovf = 1;
    else m_count = old + wr - rd;
    if (m_busy != 0) begin
      m_beat++;
      if (m_beat == B) begin
        m_busy = 0;
        m_ptr  = (m_owner + 1) % N;
      end
    end else if (bus.req != '0 && (D - old) >= B) begin
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (m_ptr + k) % N;
        if (bus.req[idx]) begin
          m_owner = idx; m_busy = 1; m_beat = 0;
          break;
        end
      end
    end
  endtask

  task automatic drive(input logic [N-1:0] r, input logic p, input logic ff);
    bus.req       = r;
    bus.pop       = p;
    bus.fifo_full = ff || (m_count == D);
    #1;
  endtask

  task automatic advance();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.req_data = '0;
    drive('0, 1'b0, 1'b0);
    advance();
    advance();
    reset = 1'b1;
    drive('0, 1'b0, 1'b0);
    vectors++;
    if (bus.grant !== 4'b0000 || bus.fifo_write !== 1'b0 || bus.fifo_read !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_strobes got grant=%b wr=%b rd=%b need 0000/0/0",
               bus.grant, bus.fifo_write, bus.fifo_read);
    end
    vectors++;
    if (bus.count !== 3'd0 || bus.empty !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_count got count=%0d empty=%b need 0/1", bus.count, bus.empty);
    end
    vectors++;
    if (bus.overflow_err !== 1'b0 || bus.underflow_err !== 1'b0 || bus.fifo_wdata !== 16'h0) begin
      miscompares++;
      $display("FAIL reset_errs got ovf=%b unf=%b wdata=%h need 0/0/0000",
               bus.overflow_err, bus.underflow_err, bus.fifo_wdata);
    end
  endtask

  task automatic test_single_burst();
    bus.req_data = '0;
    bus.req_data[2*W +: W] = 16'hA5A5;
    drive(4'b0100, 1'b0, 1'b0);
    vectors++;
    if (bus.grant !== 4'b0000) begin
      miscompares++;
      $display("FAIL grant_latency got %b need 0000", bus.grant);
    end
    advance();
    drive(4'b0100, 1'b0, 1'b0);
    vectors++;
    if (bus.grant !== 4'b0100 || bus.fifo_write !== 1'b1 || bus.fifo_wdata !== 16'hA5A5) begin
      miscompares++;
      $display("FAIL burst_beat0 got grant=%b wr=%b wdata=%h need 0100/1/a5a5",
               bus.grant, bus.fifo_write, bus.fifo_wdata);
    end
    advance();
    bus.req_data[2*W +: W] = 16'h5A5A;
    drive(4'b0100, 1'b0, 1'b0);
    vectors++;
    if (bus.grant !== 4'b0100 || bus.fifo_wdata !== 16'h5A5A) begin
      miscompares++;
      $display("FAIL burst_beat1 got grant=%b wdata=%h need 0100/5a5a", bus.grant, bus.fifo_wdata);
    end
    advance();
    drive(4'b0000, 1'b0, 1'b0);
    vectors++;
    if (bus.grant !== 4'b0000 || bus.fifo_write !== 1'b0 || bus.count !== 3'd2) begin
      miscompares++;
      $display("FAIL burst_end got grant=%b wr=%b count=%0d need 0000/0/2",
               bus.grant, bus.fifo_write, bus.count);
    end
    // Pointer now sits at 3, so of {0,3} producer 3 must win.
    drive(4'b1001, 1'b0, 1'b0);
    advance();
    drive(4'b1001, 1'b0, 1'b0);
    vectors++;
    if (bus.grant !== 4'b1000) begin
      miscompares++;
      $display("FAIL rr_ptr_three got %b need 1000", bus.grant);
    end
    advance();
    drive(4'b1001, 1'b0, 1'b0);
    advance();
    drive(4'b0000, 1'b0, 1'b0);
    vectors++;
    if (bus.count !== 3'd4) begin
      miscompares++;
      $display("FAIL fill_count got %0d need 4", bus.count);
    end
  endtask

  task automatic test_fill_block();
    for (int i = 0; i < 3; i++) begin
      drive(4'b1000, 1'b0, 1'b0);
      vectors++;
      if (bus.grant !== 4'b0000) begin
        miscompares++;
        $display("FAIL blocked_full cyc=%0d got %b need 0000", i, bus.grant);
      end
      advance();
    end
    for (int i = 0; i < 2; i++) begin
      drive(4'b1000, 1'b1, 1'b0);
      vectors++;
      if (bus.grant !== 4'b0000 || bus.fifo_read !== 1'b1) begin
        miscompares++;
        $display("FAIL drain_blocked cyc=%0d got grant=%b rd=%b need 0000/1", i, bus.grant, bus.fifo_read);
      end
      advance();
    end
    drive(4'b1000, 1'b0, 1'b0);
    vectors++;
    if (bus.count !== 3'd2 || bus.grant !== 4'b0000) begin
      miscompares++;
      $display("FAIL drained_two got count=%0d grant=%b need 2/0000", bus.count, bus.grant);
    end
    advance();
    drive(4'b1000, 1'b1, 1'b0);
    vectors++;
    if (bus.grant !== 4'b1000 || bus.fifo_read !== 1'b1) begin
      miscompares++;
      $display("FAIL grant_after_drain got grant=%b rd=%b need 1000/1", bus.grant, bus.fifo_read);
    end
    advance();
    drive(4'b1000, 1'b0, 1'b0);
    vectors++;
    if (bus.count !== 3'd2) begin
      miscompares++;
      $display("FAIL count_hold_wr_rd got %0d need 2", bus.count);
    end
    advance();
    for (int i = 0; i < 3; i++) begin
      drive(4'b0000, 1'b1, 1'b0);
      advance();
    end
    drive(4'b0000, 1'b1, 1'b0);
    vectors++;
    if (bus.count !== 3'd0 || bus.fifo_read !== 1'b0 || bus.underflow_err !== 1'b0) begin
      miscompares++;
      $display("FAIL pop_empty got count=%0d rd=%b unf=%b need 0/0/0",
               bus.count, bus.fifo_read, bus.underflow_err);
    end
    advance();
    for (int i = 0; i < 3; i++) begin
      drive(4'b0000, 1'b0, 1'b0);
      vectors++;
      if (bus.underflow_err !== 1'b1 || bus.empty !== 1'b1) begin
        miscompares++;
        $display("FAIL underflow_sticky cyc=%0d got unf=%b empty=%b need 1/1",
                 i, bus.underflow_err, bus.empty);
      end
      advance();
    end
  endtask

  task automatic test_round_robin();
    int starts[$];
    int expect_order[5] = '{0, 1, 2, 3, 0};
    logic [N-1:0] prev;
    reset = 1'b0;
    drive('0, 1'b0, 1'b0);
    advance();
    reset = 1'b1;
    prev = '0;
    for (int cyc = 0; cyc < 60 && starts.size() < 5; cyc++) begin
      drive(4'b1111, (m_count >= 2), 1'b0);
      vectors++;
      if (obs !== exp_vec()) begin
        miscompares++;
        $display("FAIL rr_model cyc=%0d got %h need %h", cyc, obs, exp_vec());
      end
      if (prev != '0 && bus.grant != '0 && bus.grant != prev) begin
        miscompares++;
        $display("FAIL rr_no_gap cyc=%0d got %b after %b need an idle cycle", cyc, bus.grant, prev);
      end
      if (bus.overflow_err !== 1'b0) begin
        miscompares++;
        $display("FAIL rr_overflow cyc=%0d got %b need 0", cyc, bus.overflow_err);
      end
      if (bus.grant != '0 && prev == '0) starts.push_back($clog2(bus.grant));
      prev = bus.grant;
      advance();
    end
    vectors++;
    if (starts.size() < 5) begin
      miscompares++;
      $display("FAIL rr_timeout got %0d grants need 5", starts.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        vectors++;
        if (starts[i] != expect_order[i]) begin
          miscompares++;
          $display("FAIL rr_order idx=%0d got %0d need %0d", i, starts[i], expect_order[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    for (int i = 0; i < 4 && m_busy != 0; i++) begin
      drive(4'b1111, 1'b0, 1'b0);
      advance();
    end
    while (m_count > 0) begin
      drive(4'b0000, 1'b1, 1'b0);
      advance();
    end
    drive(4'b0010, 1'b0, 1'b0);
    advance();
    drive(4'b0010, 1'b0, 1'b1);
    advance();
    reset = 1'b0;
    drive(4'b0010, 1'b0, 1'b0);
    vectors++;
    if (bus.grant !== 4'b0010 || bus.overflow_err !== 1'b1) begin
      miscompares++;
      $display("FAIL full_write_ovf got grant=%b ovf=%b need 0010/1", bus.grant, bus.overflow_err);
    end
    advance();
    reset = 1'b1;
    drive(4'b1011, 1'b0, 1'b0);
    vectors++;
    if (bus.grant !== 4'b0000 || bus.fifo_write !== 1'b0 || bus.count !== 3'd0 || bus.empty !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_reset_state got grant=%b wr=%b count=%0d empty=%b need 0000/0/0/1",
               bus.grant, bus.fifo_write, bus.count, bus.empty);
    end
    vectors++;
    if (bus.overflow_err !== 1'b0 || bus.underflow_err !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset_errs got ovf=%b unf=%b need 0/0", bus.overflow_err, bus.underflow_err);
    end
    advance();
    drive(4'b1011, 1'b0, 1'b0);
    vectors++;
    if (bus.grant !== 4'b0001) begin
      miscompares++;
      $display("FAIL rr_ptr_after_reset got %b need 0001", bus.grant);
    end
    advance();
    drive(4'b1011, 1'b0, 1'b0);
    advance();
  endtask

  task automatic test_random();
    logic [N-1:0] r;
    for (int cyc = 0; cyc < 400; cyc++) begin
      reset = ($urandom_range(0, 60) != 0);
      r = N'($urandom);
      if (m_busy != 0) r[m_owner] = 1'b1;
      bus.req_data = {$urandom, $urandom};
      drive(r, 1'($urandom), ($urandom_range(0, 30) == 0));
      vectors++;
      if (obs !== exp_vec()) begin
        miscompares++;
        $display("FAIL random_model cyc=%0d got %h need %h", cyc, obs, exp_vec());
      end
      advance();
    end
    reset = 1'b1;
  endtask

  initial begin
    m_busy = 0; m_owner = 0; m_beat = 0; m_ptr = 0; m_count = 0; m_ovf = 0; m_unf = 0;
    test_reset();
    test_single_burst();
    test_fill_block();
    test_round_robin();
    test_reset_mid_burst();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
